// File: rtl/frame_painter.sv
// Raster scanner and VGA write controller: sweeps the frame, feeds the background
// colour stage, re-aligns its flag with the pixel coordinates and issues one plot per pixel.
module frame_painter #(
  parameter int H_PIXELS    = 320,
  parameter int V_PIXELS    = 240,
  parameter int COLOUR_LAT  = 1,
  parameter int REFRESH_DIV = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] flag,
  output logic [8:0] x_cord,
  output logic [8:0] y_cord,
  output logic [8:0] vga_x,
  output logic [8:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  localparam logic [8:0] X_LAST = 9'(H_PIXELS - 1);
  localparam logic [8:0] Y_LAST = 9'(V_PIXELS - 1);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] R_LAST = (REFRESH_DIV > 1) ? RW'(REFRESH_DIV - 1) : '0;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

  state_t        state_q;
  logic [8:0]    x_q, y_q;
  logic [RW-1:0] refresh_q;
  logic          busy_q, done_q;
  logic [8:0]    vga_x_q, vga_y_q;
  logic [2:0]    vga_colour_q;
  logic          vga_plot_q;

  logic [8:0]    px_q [COLOUR_LAT];
  logic [8:0]    py_q [COLOUR_LAT];
  logic          pv_q [COLOUR_LAT];
  logic          any_valid;
  logic          refresh_hit;

  assign refresh_hit = (REFRESH_DIV != 0) && (refresh_q == R_LAST);

  // Coordinates travel alongside the background stage so they meet their flag.
  generate
    for (genvar gi = 0; gi < COLOUR_LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        always_ff @(posedge clock) begin
          if (reset) begin
            px_q[0] <= '0;
            py_q[0] <= '0;
            pv_q[0] <= 1'b0;
          end else begin
            px_q[0] <= x_q;
            py_q[0] <= y_q;
            pv_q[0] <= (state_q == SCAN);
          end
        end
      end else begin : g_tail
        always_ff @(posedge clock) begin
          if (reset) begin
            px_q[gi] <= '0;
            py_q[gi] <= '0;
            pv_q[gi] <= 1'b0;
          end else begin
            px_q[gi] <= px_q[gi-1];
            py_q[gi] <= py_q[gi-1];
            pv_q[gi] <= pv_q[gi-1];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < COLOUR_LAT; i++) any_valid = any_valid | pv_q[i];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      refresh_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start || refresh_hit) begin
            state_q   <= SCAN;
            busy_q    <= 1'b1;
            refresh_q <= '0;
          end else if (REFRESH_DIV != 0) begin
            refresh_q <= refresh_q + 1'b1;
          end
        end
        SCAN: begin
          if (x_q == X_LAST) begin
            x_q <= '0;
            if (y_q == Y_LAST) begin
              y_q     <= '0;
              state_q <= DRAIN;
            end else begin
              y_q <= y_q + 9'd1;
            end
          end else begin
            x_q <= x_q + 9'd1;
          end
        end
        DRAIN: begin
          // Once the delay line is empty the last pixel sits in the output register.
          if (!any_valid) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      vga_plot_q <= pv_q[COLOUR_LAT-1];
      if (pv_q[COLOUR_LAT-1]) begin
        vga_x_q      <= px_q[COLOUR_LAT-1];
        vga_y_q      <= py_q[COLOUR_LAT-1];
        vga_colour_q <= flag;
      end
    end
  end

  assign x_cord     = x_q;
  assign y_cord     = y_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_frame_painter.sv
// Directed bench for frame_painter on a reduced 32x12 frame, with a one-cycle
// background model returning x[2:0]^y[2:0]; a second instance exercises auto-refresh.
module tb_frame_painter;

  localparam int H = 32;
  localparam int V = 12;
  localparam int NPIX = H * V;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start;
  logic [2:0] flag;
  logic [8:0] x_cord, y_cord, vga_x, vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, done;

  logic       rrst, rstart;
  logic [2:0] rflag;
  logic [8:0] rx_cord, ry_cord, rvga_x, rvga_y;
  logic [2:0] rvga_colour;
  logic       rvga_plot, rbusy, rdone;

  frame_painter #(.H_PIXELS(H), .V_PIXELS(V), .COLOUR_LAT(1), .REFRESH_DIV(0)) dut (
    .clock(clk), .reset(rst), .start(start), .flag(flag),
    .x_cord(x_cord), .y_cord(y_cord), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy), .done(done)
  );

  frame_painter #(.H_PIXELS(H), .V_PIXELS(V), .COLOUR_LAT(1), .REFRESH_DIV(100)) rdut (
    .clock(clk), .reset(rrst), .start(rstart), .flag(rflag),
    .x_cord(rx_cord), .y_cord(ry_cord), .vga_x(rvga_x), .vga_y(rvga_y),
    .vga_colour(rvga_colour), .vga_plot(rvga_plot), .busy(rbusy), .done(rdone)
  );

  // Background stage: one clock of latency from coordinates to flag.
  always @(posedge clk) begin
    flag  <= x_cord[2:0] ^ y_cord[2:0];
    rflag <= rx_cord[2:0] ^ ry_cord[2:0];
  end

  int vectors = 0;
  int miscompares = 0;
  int exp_x, exp_y, plots;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rrst = 1'b1; rstart = 1'b0;
    repeat (3) step();
    vectors++;
    if ({busy, done, vga_plot} !== 3'b000) begin
      miscompares++; $display("FAIL reset_ctrl: busy/done/plot=%b want 000", {busy, done, vga_plot});
    end
    vectors++;
    if ({x_cord, y_cord} !== 18'd0) begin
      miscompares++; $display("FAIL reset_scan: x=%0d y=%0d want 0 0", x_cord, y_cord);
    end
    vectors++;
    if ({vga_x, vga_y, vga_colour} !== 21'd0) begin
      miscompares++; $display("FAIL reset_vga: x=%0d y=%0d c=%0d want 0", vga_x, vga_y, vga_colour);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL idle_no_start: busy=%b want 0", busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_start_latency();
    repeat (4) step();
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if ({busy, vga_plot, x_cord} !== {1'b1, 1'b0, 9'd0}) begin
      miscompares++; $display("FAIL start_busy: busy=%b plot=%b x=%0d want 1 0 0", busy, vga_plot, x_cord);
    end
    step();
    vectors++;
    if ({vga_plot, x_cord} !== {1'b0, 9'd1}) begin
      miscompares++; $display("FAIL scan_advance: plot=%b x=%0d want 0 1", vga_plot, x_cord);
    end
    step();
    vectors++;
    if ({vga_plot, vga_x, vga_y, vga_colour} !== {1'b1, 9'd0, 9'd0, 3'd0}) begin
      miscompares++; $display("FAIL first_plot: plot=%b (%0d,%0d) c=%0d want 1 (0,0) 0",
                              vga_plot, vga_x, vga_y, vga_colour);
    end
    exp_x = 1; exp_y = 0; plots = 1;
    $display("test_start_latency done");
  endtask

  task automatic test_full_frame();
    bit done_seen = 0;
    int px = 0, py = 0;
    for (int g = 0; g < NPIX + 50 && !done_seen; g++) begin
      step();
      if (vga_plot) begin
        vectors++;
        if ({vga_x, vga_y, vga_colour} !== {9'(exp_x), 9'(exp_y), 3'(exp_x ^ exp_y)}) begin
          miscompares++; $display("FAIL raster_pixel: got (%0d,%0d) c=%0d want (%0d,%0d) c=%0d",
                                  vga_x, vga_y, vga_colour, exp_x, exp_y, (exp_x ^ exp_y) & 7);
        end
        if (vga_x == 9'd0 && vga_y == 9'd6) begin
          vectors++;
          if (px != H - 1 || py != 5) begin
            miscompares++; $display("FAIL line_wrap: before (0,6) got (%0d,%0d) want (%0d,5)", px, py, H - 1);
          end
        end
        px = vga_x; py = vga_y; plots++;
        if (exp_x == H - 1) begin exp_x = 0; exp_y++; end else exp_x++;
      end
      if (done) begin
        done_seen = 1;
        vectors++;
        if (plots != NPIX) begin
          miscompares++; $display("FAIL frame_count: plots=%0d want %0d", plots, NPIX);
        end
        vectors++;
        if (px != H - 1 || py != V - 1) begin
          miscompares++; $display("FAIL last_pixel: got (%0d,%0d) want (%0d,%0d)", px, py, H - 1, V - 1);
        end
        vectors++;
        if ({busy, vga_plot} !== 2'b10) begin
          miscompares++; $display("FAIL done_cycle: busy=%b plot=%b want 1 0", busy, vga_plot);
        end
      end
    end
    vectors++;
    if (!done_seen) begin
      miscompares++; $display("FAIL frame_timeout: done=0 want 1 within budget");
    end
    step();
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++; $display("FAIL after_done: busy=%b done=%b want 0 0", busy, done);
    end
    $display("test_full_frame done plots=%0d", plots);
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    int busy_rises = 0;
    bit prev_busy = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    exp_x = 0; exp_y = 0; plots = 0;
    for (int g = 0; g < NPIX + 60 && dones == 0; g++) begin
      step();
      start = 1'b0;
      if (vga_plot) begin
        vectors++;
        if ({vga_x, vga_y} !== {9'(exp_x), 9'(exp_y)}) begin
          miscompares++; $display("FAIL busy_raster: got (%0d,%0d) want (%0d,%0d)", vga_x, vga_y, exp_x, exp_y);
        end
        plots++;
        if (exp_x == H - 1) begin exp_x = 0; exp_y++; end else exp_x++;
        if (plots == 100) start = 1'b1;
      end
      if (done) dones++;
    end
    vectors++;
    if (plots != NPIX) begin
      miscompares++; $display("FAIL busy_plots: plots=%0d want %0d", plots, NPIX);
    end
    prev_busy = busy;
    for (int g = 0; g < 40; g++) begin
      step();
      if (busy && !prev_busy) busy_rises++;
      prev_busy = busy;
    end
    vectors++;
    if (busy_rises != 0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL no_queue: extra frames=%0d busy=%b want 0 0", busy_rises, busy);
    end
    $display("test_start_ignored done plots=%0d", plots);
  endtask

  task automatic test_reset_midframe();
    start = 1'b1;
    step();
    start = 1'b0;
    plots = 0;
    for (int g = 0; g < NPIX && plots < 200; g++) begin
      step();
      if (vga_plot) plots++;
    end
    vectors++;
    if (plots != 200) begin
      miscompares++; $display("FAIL midframe_reach: plots=%0d want 200", plots);
    end
    rst = 1'b1;
    step();
    vectors++;
    if ({vga_plot, busy, done, x_cord, y_cord} !== 21'd0) begin
      miscompares++; $display("FAIL abort: plot=%b busy=%b done=%b x=%0d y=%0d want all 0",
                              vga_plot, busy, done, x_cord, y_cord);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (vga_plot !== 1'b0) begin
      miscompares++; $display("FAIL abort_quiet: plot=%b want 0", vga_plot);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    vectors++;
    if ({vga_plot, vga_x, vga_y} !== {1'b1, 9'd0, 9'd0}) begin
      miscompares++; $display("FAIL restart_origin: plot=%b (%0d,%0d) want 1 (0,0)", vga_plot, vga_x, vga_y);
    end
    $display("test_reset_midframe done");
  endtask

  task automatic test_refresh();
    int wait_cyc = 0;
    int gap;
    int rplots;
    rrst = 1'b0;
    while (!rbusy && wait_cyc < 300) begin step(); wait_cyc++; end
    vectors++;
    if (!rbusy) begin
      miscompares++; $display("FAIL refresh_first: busy=%b want 1 within 300 cycles", rbusy);
    end
    for (int f = 0; f < 3; f++) begin
      rplots = 0;
      for (int g = 0; g < NPIX + 50 && !rdone; g++) begin
        step();
        if (rvga_plot) rplots++;
      end
      vectors++;
      if (rplots != NPIX || !rdone) begin
        miscompares++; $display("FAIL refresh_frame%0d: plots=%0d done=%b want %0d 1", f, rplots, rdone, NPIX);
      end
      $display("refresh frame %0d plots=%0d", f, rplots);
      if (f < 2) begin
        gap = 0;
        step();
        while (!rbusy && gap < 300) begin gap++; step(); end
        vectors++;
        if (gap != 100) begin
          miscompares++; $display("FAIL refresh_gap%0d: idle=%0d want 100", f, gap);
        end
      end
    end
    $display("test_refresh done");
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_full_frame();
    test_start_ignored();
    test_reset_midframe();
    test_refresh();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
